// File: rtl/solver_sequencer.sv
// Streams ROM bytes into a Solver over valid/ready, latches its answer and raises Done/Error.
// Optional WAIT_DONE timeout is compiled in with SEQ_WATCHDOG_EN.
module solver_sequencer #(
  parameter int INPUT_LEN   = 1024,
  parameter int ADDR_W      = 16,
  parameter int ANSWER_W    = 64,
  parameter int WDOG_CYCLES = 2**20
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Start,
  output logic [ADDR_W-1:0]   RomAddr,
  input  logic [7:0]          RomData,
  output logic                InValid,
  output logic [7:0]          InData,
  output logic                InLast,
  input  logic                InReady,
  input  logic                SolverDone,
  input  logic [ANSWER_W-1:0] SolverAnswer,
  input  logic [ANSWER_W-1:0] ExpectedAnswer,
  output logic [ANSWER_W-1:0] Answer,
  output logic                Busy,
  output logic                Done,
  output logic                Error
);

  typedef enum logic [2:0] {IDLE, FETCH, PRESENT, WAIT_DONE, FINISH} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(INPUT_LEN - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              valid_nxt, last_nxt, done_nxt, error_nxt, latch_ans;
  logic              wdog_hit;

`ifdef SEQ_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_cnt;

  // Held at zero outside WAIT_DONE, so it restarts on every entry.
  always_ff @(posedge Clk) begin
    if (Rst || state != WAIT_DONE) wdog_cnt <= '0;
    else                           wdog_cnt <= wdog_cnt + 1'b1;
  end

  assign wdog_hit = (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));
`else
  assign wdog_hit = 1'b0;
`endif

  // RomAddr is frozen for all of PRESENT, so the 1-cycle ROM keeps returning
  // the pending byte; forwarding it keeps the 2-cycle/byte rate.
  assign InData = InValid ? RomData : 8'h00;
  assign Busy   = (state == FETCH) || (state == PRESENT) || (state == WAIT_DONE);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= IDLE;
      RomAddr <= '0;
      InValid <= 1'b0;
      InLast  <= 1'b0;
      Done    <= 1'b0;
      Error   <= 1'b0;
      Answer  <= '0;
    end else begin
      state   <= state_nxt;
      RomAddr <= addr_nxt;
      InValid <= valid_nxt;
      InLast  <= last_nxt;
      Done    <= done_nxt;
      Error   <= error_nxt;
      if (latch_ans) Answer <= SolverAnswer;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = RomAddr;
    valid_nxt = InValid;
    last_nxt  = InLast;
    done_nxt  = Done;
    error_nxt = Error;
    latch_ans = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          addr_nxt  = '0;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        if (SolverDone) begin
          latch_ans = 1'b1;
          error_nxt = 1'b1;
          state_nxt = FINISH;
        end else begin
          valid_nxt = 1'b1;
          last_nxt  = (RomAddr == LAST_ADDR);
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        // A done pulse before the last byte is accepted is a protocol error.
        if (SolverDone) begin
          latch_ans = 1'b1;
          error_nxt = 1'b1;
          valid_nxt = 1'b0;
          last_nxt  = 1'b0;
          state_nxt = FINISH;
        end else if (InReady) begin
          valid_nxt = 1'b0;
          last_nxt  = 1'b0;
          if (InLast) begin
            state_nxt = WAIT_DONE;
          end else begin
            addr_nxt  = RomAddr + 1'b1;
            state_nxt = FETCH;
          end
        end
      end
      WAIT_DONE: begin
        if (SolverDone) begin
          latch_ans = 1'b1;
          done_nxt  = 1'b1;
          error_nxt = (SolverAnswer != ExpectedAnswer);
          state_nxt = FINISH;
        end else if (wdog_hit) begin
          error_nxt = 1'b1;
          state_nxt = FINISH;
        end
      end
      FINISH: begin
        state_nxt = FINISH;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_solver_sequencer.sv
// Randomized and directed bench for solver_sequencer against a byte-stream reference model.
module tb_solver_sequencer;

  localparam int LEN  = 4;
  localparam int AW   = 4;
  localparam int ANSW = 64;
  localparam int WDOG = 16;

  logic            Clk, Rst, Start;
  logic [AW-1:0]   RomAddr;
  logic [7:0]      RomData;
  logic            InValid, InLast, InReady;
  logic [7:0]      InData;
  logic            SolverDone;
  logic [ANSW-1:0] SolverAnswer, ExpectedAnswer, Answer;
  logic            Busy, Done, Error;

  logic [7:0] rom [LEN];
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  solver_sequencer #(
    .INPUT_LEN(LEN), .ADDR_W(AW), .ANSWER_W(ANSW), .WDOG_CYCLES(WDOG)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start),
    .RomAddr(RomAddr), .RomData(RomData),
    .InValid(InValid), .InData(InData), .InLast(InLast), .InReady(InReady),
    .SolverDone(SolverDone), .SolverAnswer(SolverAnswer), .ExpectedAnswer(ExpectedAnswer),
    .Answer(Answer), .Busy(Busy), .Done(Done), .Error(Error)
  );

  initial begin
    Clk = 1'b0;
    forever #4 Clk = ~Clk;
  end

  always @(posedge Clk) cyc <= cyc + 1;

  // Synchronous ROM, one cycle of read latency.
  always @(posedge Clk) RomData <= (int'(RomAddr) < LEN) ? rom[int'(RomAddr)] : 8'hEE;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_addr"}, 64'(RomAddr), 0);
    chk({tag, "_valid"}, 64'(InValid), 0);
    chk({tag, "_data"}, 64'(InData), 0);
    chk({tag, "_last"}, 64'(InLast), 0);
    chk({tag, "_answer"}, Answer, 0);
    chk({tag, "_busy"}, 64'(Busy), 0);
    chk({tag, "_done"}, 64'(Done), 0);
    chk({tag, "_error"}, 64'(Error), 0);
  endtask

  task automatic do_reset();
    Rst = 1'b1; Start = 1'b0; SolverDone = 1'b0; InReady = 1'b1;
    step();
    step();
    Rst = 1'b0;
    chk_idle_zero("reset");
  endtask

  // One run from Start: the model is the ROM byte list, the handshake rule and the
  // answer comparison. done_delay < 0 means the Solver never answers.
  task automatic run_case(input string name, input int stall_byte, input int stall_len,
                          input bit rand_ready, input int done_delay, input int early_byte,
                          input int rst_byte, input logic [63:0] ans, input logic [63:0] exp_ans);
    int idx, stalled, last_edge, prev_xfer, exp_cnt;
    bit finished, hold_prev, early, rst_fire, fire, no_stalls;
    logic [7:0] prev_data;
    logic prev_last;
    idx = 0; stalled = 0; last_edge = -1; prev_xfer = -1;
    finished = 0; hold_prev = 0; early = 0; rst_fire = 0;
    prev_data = 8'h00; prev_last = 1'b0;
    no_stalls = !rand_ready && stall_len == 0;
    exp_cnt = (early_byte >= 0) ? early_byte : (rst_byte >= 0) ? rst_byte : LEN;
    SolverAnswer = ans; ExpectedAnswer = exp_ans;
    Start = 1'b1;
    step();
    Start = 1'b0;
    for (int n = 0; n < 2000 && !finished; n++) begin
      chk({name, "_busy"}, 64'(Busy), 1);
      chk({name, "_done_run"}, 64'(Done), 0);
      chk({name, "_err_run"}, 64'(Error), 0);
      chk({name, "_addr_range"}, 64'(int'(RomAddr) <= LEN - 1), 1);
      if (hold_prev) begin
        chk({name, "_hold_valid"}, 64'(InValid), 1);
        chk({name, "_hold_data"}, 64'(InData), 64'(prev_data));
        chk({name, "_hold_last"}, 64'(InLast), 64'(prev_last));
      end
      if (idx == LEN) chk({name, "_valid_after_last"}, 64'(InValid), 0);
      if (InValid && idx < LEN) chk({name, "_pending_data"}, 64'(InData), 64'(rom[idx]));
      InReady = 1'b1; SolverDone = 1'b0;
      if (rand_ready) InReady = ($urandom_range(0, 2) != 0);
      if (InValid && idx == stall_byte && stalled < stall_len) begin
        InReady = 1'b0; stalled++;
      end
      if (InValid && idx == early_byte) begin
        InReady = 1'b0; SolverDone = 1'b1; early = 1;
      end
      if (InValid && idx == rst_byte) begin
        InReady = 1'b0; Rst = 1'b1; rst_fire = 1;
      end
      if (last_edge >= 0 && done_delay >= 0 && cyc + 1 == last_edge + done_delay) SolverDone = 1'b1;
      fire = SolverDone;
      hold_prev = InValid && !InReady;
      prev_data = InData; prev_last = InLast;
      if (InValid && InReady) begin
        chk({name, "_xfer_data"}, 64'(InData), 64'(rom[idx]));
        chk({name, "_xfer_last"}, 64'(InLast), 64'(idx == LEN - 1));
        if (no_stalls && prev_xfer >= 0) chk({name, "_gap"}, 64'(cyc + 1 - prev_xfer), 2);
        prev_xfer = cyc + 1;
        idx++;
        if (idx == LEN) last_edge = cyc + 1;
      end
      step();
      SolverDone = 1'b0;
      if (rst_fire) begin
        Rst = 1'b0;
        chk_idle_zero({name, "_midrst"});
        finished = 1;
      end else if (fire) begin
        chk({name, "_done"}, 64'(Done), early ? 0 : 1);
        chk({name, "_error"}, 64'(Error), early ? 1 : 64'(ans != exp_ans));
        chk({name, "_answer"}, Answer, ans);
        chk({name, "_busy_end"}, 64'(Busy), 0);
        chk({name, "_valid_end"}, 64'(InValid), 0);
        finished = 1;
      end else if (done_delay < 0 && last_edge >= 0) begin
`ifdef SEQ_WATCHDOG_EN
        if (cyc == last_edge + WDOG) begin
          chk({name, "_wdog_error"}, 64'(Error), 1);
          chk({name, "_wdog_done"}, 64'(Done), 0);
          chk({name, "_wdog_busy"}, 64'(Busy), 0);
          finished = 1;
        end
`else
        if (cyc == last_edge + 1000) begin
          chk({name, "_nowdog_error"}, 64'(Error), 0);
          chk({name, "_nowdog_done"}, 64'(Done), 0);
          chk({name, "_nowdog_busy"}, 64'(Busy), 1);
          finished = 1;
        end
`endif
      end
    end
    chk({name, "_finished"}, 64'(finished), 1);
    chk({name, "_xfer_count"}, 64'(idx), 64'(exp_cnt));
    InReady = 1'b1;
  endtask

  initial begin
    logic [63:0] ans, expv;
    Rst = 1'b1; Start = 1'b0; InReady = 1'b1; SolverDone = 1'b0;
    SolverAnswer = '0; ExpectedAnswer = '0;
    rom[0] = 8'h31; rom[1] = 8'h32; rom[2] = 8'h0A; rom[3] = 8'h33;
    do_reset();

    run_case("match", -1, 0, 0, 3, -1, -1, 64'd42, 64'd42);
    do_reset();
    run_case("mismatch", -1, 0, 0, 3, -1, -1, 64'd42, 64'd41);
    do_reset();
    run_case("stall", 1, 5, 0, 3, -1, -1, 64'd42, 64'd42);
    do_reset();

    run_case("early", -1, 0, 0, 3, 0, -1, 64'd7, 64'd42);
    Start = 1'b1;
    step();
    Start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("early_start_busy", 64'(Busy), 0);
    chk("early_start_error", 64'(Error), 1);
    chk("early_start_done", 64'(Done), 0);
    chk("early_start_valid", 64'(InValid), 0);
    chk("early_start_addr", 64'(RomAddr), 0);
    chk("early_start_answer", Answer, 64'd7);
    do_reset();

    run_case("rst", -1, 0, 0, 3, -1, 1, 64'd42, 64'd42);
    run_case("after_rst", -1, 0, 0, 3, -1, -1, 64'd42, 64'd42);
    do_reset();

    run_case("no_done", -1, 0, 0, -1, -1, -1, 64'd42, 64'd42);
    do_reset();

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < LEN; i++) rom[i] = 8'($urandom);
      ans  = {$urandom(), $urandom()};
      expv = ($urandom_range(0, 1) != 0) ? ans : (ans ^ (64'd1 << $urandom_range(0, 63)));
      run_case("random", -1, 0, 1, int'($urandom_range(1, 6)), -1, -1, ans, expv);
      do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
